// File: rtl/result_ram_writer.sv
// Writes one block of DEPTH signed PE results as clamped 8-bit pixels to consecutive RAM addresses.
// Latency: first write registered on the edge after acceptance; backpressure: ready low while writing or done, excess valids flag overflow.
module result_ram_writer #(
   parameter int RAM_ADDR_WIDTH = 6,
   parameter int RAM_DATA_WIDTH = 8,
   parameter int PE_DATA_WIDTH  = 16,
   parameter int DEPTH          = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in,
   input  logic                            data_valid,
   output logic                            ready,
   output logic [RAM_ADDR_WIDTH-1:0]       ram_address,
   output logic [RAM_DATA_WIDTH-1:0]       ram_wdata,
   output logic                            ram_we,
   output logic [RAM_ADDR_WIDTH-1:0]       block_count,
   output logic                            overflow,
   output logic                            done
);

   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                           state_q, state_d;
   logic [PE_DATA_WIDTH*DEPTH-1:0]   hold;
   logic [RAM_ADDR_WIDTH-1:0]        ptr;
   logic [LW-1:0]                    lane_cnt;
   logic                             last_lane;

   function automatic logic [RAM_DATA_WIDTH-1:0] clamp(input logic [PE_DATA_WIDTH-1:0] v);
      if (v[PE_DATA_WIDTH-1])
         clamp = '0;
      else if (|v[PE_DATA_WIDTH-2:RAM_DATA_WIDTH])
         clamp = '1;
      else
         clamp = v[RAM_DATA_WIDTH-1:0];
   endfunction

   assign last_lane = (lane_cnt == LW'(DEPTH));
   assign ready     = (state_q == IDLE);
   assign done      = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (data_valid) state_d = WRITE;
            // pointer has already stepped past the last lane, so zero means the image wrapped
            WRITE:   if (last_lane) state_d = (ptr == '0) ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold        <= '0;
         ptr         <= '0;
         lane_cnt    <= '0;
         ram_address <= '0;
         ram_wdata   <= '0;
         ram_we      <= 1'b0;
         block_count <= '0;
         overflow    <= 1'b0;
      end else if (start) begin
         ptr         <= '0;
         lane_cnt    <= '0;
         ram_we      <= 1'b0;
         block_count <= '0;
         overflow    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_valid) begin
                  hold        <= data_in >> PE_DATA_WIDTH;
                  ram_we      <= 1'b1;
                  ram_address <= ptr;
                  ram_wdata   <= clamp(data_in[PE_DATA_WIDTH-1:0]);
                  lane_cnt    <= LW'(1);
                  ptr         <= ptr + RAM_ADDR_WIDTH'(1);
               end else begin
                  ram_we      <= 1'b0;
               end
            end
            WRITE: begin
               if (data_valid)
                  overflow <= 1'b1;
               if (!last_lane) begin
                  hold        <= hold >> PE_DATA_WIDTH;
                  ram_we      <= 1'b1;
                  ram_address <= ptr;
                  ram_wdata   <= clamp(hold[PE_DATA_WIDTH-1:0]);
                  lane_cnt    <= lane_cnt + LW'(1);
                  ptr         <= ptr + RAM_ADDR_WIDTH'(1);
               end else begin
                  ram_we      <= 1'b0;
                  ram_address <= ptr;
                  lane_cnt    <= '0;
                  block_count <= block_count + RAM_ADDR_WIDTH'(1);
               end
            end
            default: begin
               if (data_valid)
                  overflow <= 1'b1;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_ram_writer.sv
// Directed bench for result_ram_writer: clamp, full image, overflow, reset mid-block, done handling, start re-arm.
module tb_result_ram_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] data_in;
   logic        data_valid;
   logic        ready;
   logic [5:0]  ram_address;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [5:0]  block_count;
   logic        overflow;
   logic        done;

   int vecs = 0;
   int errs = 0;
   int wr_count = 0;
   logic [7:0] mem [0:63];

   result_ram_writer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .ready       (ready),
      .ram_address (ram_address),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .block_count (block_count),
      .overflow    (overflow),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_address] <= ram_wdata;
         wr_count <= wr_count + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] blk);
      int n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         errs++;
         $display("FAIL send_block_ready_timeout: ready=%b required 1 within 20 cycles", ready);
      end
      data_valid = 1'b1;
      data_in    = blk;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (ready !== 1'b1)     begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
      vecs++; if (ram_we !== 1'b0)    begin errs++; $display("FAIL reset_we: got %b want 0", ram_we); end
      vecs++; if (ram_address !== 6'd0) begin errs++; $display("FAIL reset_addr: got %0d want 0", ram_address); end
      vecs++; if (ram_wdata !== 8'd0) begin errs++; $display("FAIL reset_wdata: got %0h want 0", ram_wdata); end
      vecs++; if (block_count !== 6'd0) begin errs++; $display("FAIL reset_bc: got %0d want 0", block_count); end
      vecs++; if (overflow !== 1'b0)  begin errs++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      vecs++; if (done !== 1'b0)      begin errs++; $display("FAIL reset_done: got %b want 0", done); end
   endtask

   task automatic test_clamp();
      logic [7:0] exp [4];
      exp[0] = 8'h10; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'hFF;
      send_block({16'h00FF, 16'hFFF6, 16'h012C, 16'h0010});
      for (int k = 0; k < 4; k++) begin
         vecs++; if (ram_we !== 1'b1) begin errs++; $display("FAIL clamp_we[%0d]: got %b want 1", k, ram_we); end
         vecs++; if (ram_address !== 6'(k)) begin errs++; $display("FAIL clamp_addr[%0d]: got %0d want %0d", k, ram_address, k); end
         vecs++; if (ram_wdata !== exp[k]) begin errs++; $display("FAIL clamp_data[%0d]: got %0h want %0h", k, ram_wdata, exp[k]); end
         vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL clamp_ready_low[%0d]: got %b want 0", k, ready); end
         @(negedge clk);
      end
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL clamp_ready_back: got %b want 1", ready); end
      vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL clamp_we_off: got %b want 0", ram_we); end
      vecs++; if (block_count !== 6'd1) begin errs++; $display("FAIL clamp_bc: got %0d want 1", block_count); end
   endtask

   task automatic run_image();
      int n = 0;
      do_reset();
      for (int b = 0; b < 16; b++)
         send_block({16'(4*b+4), 16'(4*b+3), 16'(4*b+2), 16'(4*b+1)});
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_full_image();
      run_image();
      vecs++; if (done !== 1'b1) begin errs++; $display("FAIL image_done: got %b want 1", done); end
      for (int n = 0; n < 64; n++) begin
         vecs++;
         if (mem[n] !== 8'(n+1)) begin errs++; $display("FAIL image_mem[%0d]: got %0d want %0d", n, mem[n], n+1); end
      end
      vecs++; if (ram_address !== 6'd0) begin errs++; $display("FAIL image_addr: got %0d want 0", ram_address); end
      vecs++; if (block_count !== 6'd16) begin errs++; $display("FAIL image_bc: got %0d want 16", block_count); end
      vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL image_ovf: got %b want 0", overflow); end
      vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL image_ready: got %b want 0", ready); end
   endtask

   task automatic test_done_ignore();
      int n0 = wr_count;
      data_valid = 1'b1;
      data_in    = {16'd9, 16'd9, 16'd9, 16'd9};
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vecs++; if (wr_count - n0 !== 0) begin errs++; $display("FAIL done_nowrite: got %0d writes want 0", wr_count - n0); end
      vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL done_ovf: got %b want 1", overflow); end
      vecs++; if (done !== 1'b1) begin errs++; $display("FAIL done_held: got %b want 1", done); end
   endtask

   task automatic test_start_rearm();
      int n0 = wr_count;
      start      = 1'b1;
      data_valid = 1'b1;
      data_in    = {16'd50, 16'd50, 16'd50, 16'd50};
      @(negedge clk);
      start      = 1'b0;
      data_valid = 1'b0;
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL start_done: got %b want 0", done); end
      vecs++; if (block_count !== 6'd0) begin errs++; $display("FAIL start_bc: got %0d want 0", block_count); end
      vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL start_ovf: got %b want 0", overflow); end
      vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL start_we: got %b want 0", ram_we); end
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL start_ready: got %b want 1", ready); end
      send_block({16'd23, 16'd22, 16'd21, 16'd20});
      for (int k = 0; k < 4; k++) begin
         vecs++; if (ram_address !== 6'(k) || ram_we !== 1'b1) begin errs++; $display("FAIL start_addr[%0d]: got %0d/we=%b want %0d/we=1", k, ram_address, ram_we, k); end
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         vecs++; if (mem[k] !== 8'(20+k)) begin errs++; $display("FAIL start_mem[%0d]: got %0d want %0d", k, mem[k], 20+k); end
      end
      vecs++; if (wr_count - n0 !== 4) begin errs++; $display("FAIL start_wrcount: got %0d want 4", wr_count - n0); end
   endtask

   task automatic test_overflow();
      int n0;
      do_reset();
      n0 = wr_count;
      data_valid = 1'b1;
      data_in    = {16'd4, 16'd3, 16'd2, 16'd1};
      @(negedge clk);
      data_in    = {16'd104, 16'd103, 16'd102, 16'd101};
      @(negedge clk);
      data_valid = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      vecs++; if (wr_count - n0 !== 4) begin errs++; $display("FAIL ovf_wrcount: got %0d want 4", wr_count - n0); end
      for (int k = 0; k < 4; k++) begin
         vecs++; if (mem[k] !== 8'(k+1)) begin errs++; $display("FAIL ovf_mem[%0d]: got %0d want %0d", k, mem[k], k+1); end
      end
      vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", overflow); end
      vecs++; if (block_count !== 6'd1) begin errs++; $display("FAIL ovf_bc: got %0d want 1", block_count); end
      send_block({16'd8, 16'd7, 16'd6, 16'd5});
      for (int i = 0; i < 6; i++) @(negedge clk);
      vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_block({16'd8, 16'd7, 16'd6, 16'd5});
      @(negedge clk);
      vecs++; if (ram_address !== 6'd1 || ram_we !== 1'b1) begin errs++; $display("FAIL mid_lane1: got %0d/we=%b want 1/we=1", ram_address, ram_we); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL mid_we: got %b want 0", ram_we); end
      vecs++; if (ram_address !== 6'd0) begin errs++; $display("FAIL mid_addr: got %0d want 0", ram_address); end
      vecs++; if (block_count !== 6'd0) begin errs++; $display("FAIL mid_bc: got %0d want 0", block_count); end
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %b want 1", ready); end
      send_block({16'd12, 16'd11, 16'd10, 16'd9});
      vecs++; if (ram_address !== 6'd0 || ram_wdata !== 8'd9) begin errs++; $display("FAIL mid_restart: got %0d/%0d want 0/9", ram_address, ram_wdata); end
      for (int i = 0; i < 5; i++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         vecs++; if (mem[k] !== 8'(9+k)) begin errs++; $display("FAIL mid_mem[%0d]: got %0d want %0d", k, mem[k], 9+k); end
      end
      vecs++; if (block_count !== 6'd1) begin errs++; $display("FAIL mid_bc_after: got %0d want 1", block_count); end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      test_reset();
      test_clamp();
      test_overflow();
      test_reset_mid();
      test_full_image();
      test_done_ignore();
      test_start_rearm();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/result_ram_writer.md
Name: result_ram_writer

Overview:
- Downstream stage of the brightness systolic array.
- Accepts one processed block of DEPTH PE results, packed as PE_DATA_WIDTH lanes on a single bus, and writes the results as 8-bit pixels into the output RAM.
- Writes use consecutive addresses, one pixel per clock.
- Clamps each signed PE result to 0..255, counts completed blocks, and asserts done once the full image (2**RAM_ADDR_WIDTH pixels) has been written.

Parameters:
RAM_ADDR_WIDTH, 6, output RAM address width; image size = 2**RAM_ADDR_WIDTH pixels
RAM_DATA_WIDTH, 8, output pixel width; clamp ceiling = 2**RAM_DATA_WIDTH-1
PE_DATA_WIDTH, 16, width of one PE result lane, signed two's complement
DEPTH, 4, lanes per block; 2**RAM_ADDR_WIDTH must be a multiple of DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; re-arms the writer (pointer to 0, clears done and overflow)
data_in  input  PE_DATA_WIDTH*DEPTH  packed block; lane i = data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH]
data_valid  input  1  block on data_in is valid this cycle
ready  output  1  high when a block can be accepted (state IDLE)
ram_address  output  RAM_ADDR_WIDTH  write address, registered
ram_wdata  output  RAM_DATA_WIDTH  clamped pixel, registered
ram_we  output  1  write enable, registered
block_count  output  RAM_ADDR_WIDTH  number of completed blocks since reset/start
overflow  output  1  sticky; data_valid seen while not ready
done  output  1  full image written; held until start or reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ram_address=0, ram_wdata=0, ram_we=0; block_count=0; overflow=0; done=0; internal write pointer=0; lane counter=0. Reset overrides every other input, including mid-block.
- States:
  - IDLE: ready=1.
  - WRITE: ready=0.
  - DONE: ready=0, done=1.
- IDLE to WRITE: on an edge with data_valid=1.
  - Latch data_in into a holding register.
  - Register ram_we=1, ram_address=pointer, ram_wdata=clamp(lane0).
  - Set lane counter=1 and pointer=pointer+1.
- WRITE, lane counter < DEPTH: at each edge, write clamp(lane[counter]) to the pointer address, pointer+1, counter+1.
  - Lanes 0..DEPTH-1 land at consecutive ascending addresses on DEPTH consecutive edges, with no gaps.
- WRITE, after the last lane: ram_we=0 and block_count+1. Next state:
  - DONE if the pointer wrapped to 0 (2**RAM_ADDR_WIDTH pixels written). In this case done=1 and ram_address=0.
  - IDLE otherwise.
- Latency and throughput:
  - First write is visible in the cycle after the accepting edge.
  - ready returns high DEPTH edges after acceptance.
  - Sustained throughput is one block per DEPTH+1 cycles.
- Clamp rule, per lane, treating the lane as signed:
  - value < 0 gives 0.
  - value > 255 gives 255.
  - otherwise the value's low 8 bits.
- data_valid while ready=0 (WRITE or DONE): the block is dropped, overflow is set (sticky), and no RAM side effect occurs.
- DONE: ignores data_valid (sets overflow) and stays in DONE until start.
- start, any state:
  - Next edge: state=IDLE, pointer=0, block_count=0, done=0, overflow=0, ram_we=0.
  - If start is pulsed mid-WRITE, the remaining lanes are abandoned.
  - start has priority over data_valid in the same cycle; the block is not accepted and overflow is not set.
- block_count width is sufficient: the maximum 2**RAM_ADDR_WIDTH/DEPTH is 16 blocks. Its reported value at done is 16 mod 64 = 16.
- ram_wdata holds its last value while ram_we=0.

Test Plan:
- Clamp, single block:
  - Stimulus: reset, then data_valid with lanes {0x0010, 0x012C, 0xFFF6, 0x00FF} (lane0..3).
  - Required: writes 0x10@0, 0xFF@1, 0x00@2, 0xFF@3 on 4 consecutive cycles starting the cycle after acceptance; ready low for exactly 4 cycles; block_count=1.
- Full image:
  - Stimulus: 16 blocks with lane i of block b = 4b+i+1, each block presented as soon as ready.
  - Required: RAM[n]=n+1 for n=0..63; done=1 after the 16th block; ram_address=0; block_count=16; overflow=0.
- Overflow:
  - Stimulus: data_valid held high for 2 cycles at acceptance.
  - Required: only the first block is written (4 writes); overflow=1 and stays 1 until start.
- Reset mid-write:
  - Stimulus: assert reset after lane 1 of a block is written.
  - Required: next edge gives ram_we=0, ram_address=0, block_count=0, state IDLE, ready=1; the next block writes from address 0.
- start re-arm:
  - Stimulus: after done, pulse start together with data_valid.
  - Required: done=0, block_count=0, overflow=0, no write that cycle; the following block is written at addresses 0..3.
- Stimulus: data_valid during DONE. Required: no ram_we, overflow=1, done stays 1.
